rv32i_fetch: RTL

//   Instruction fetch stage directly upstream of the core's decode stage; drives the memory model's

---
 rtl/rv32i_fetch.sv | 83 ++++++++
 1 files changed

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch stage: drives the instruction memory port, buffers {pc, instr}
// in a small prefetch FIFO and hands entries to decode over valid/ready; redirects flush.
module rv32i_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_en,
  output logic [31:0]                      imem_addr,
  input  logic [31:0]                      imem_rdata,
  input  logic                             redirect_valid,
  input  logic [31:0]                      redirect_pc,
  output logic                             if_valid,
  input  logic                             if_ready,
  output logic [31:0]                      if_instr,
  output logic [31:0]                      if_pc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int unsigned   PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW    = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [31:0]   NOP   = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem    [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          unused_bits;

  // Redirect target low bits are dropped to keep the fetch address word-aligned.
  assign unused_bits = ^redirect_pc[1:0];

  assign imem_addr  = fetch_pc;
  assign fifo_count = count;
  assign if_valid   = (count != '0) & ~redirect_valid;
  assign if_instr   = if_valid ? instr_mem[head] : NOP;
  assign if_pc      = if_valid ? pc_mem[head] : '0;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign pop  = if_valid & if_ready & ~redirect_valid;
  assign push = fetch_en & ~redirect_valid & ((count < DEPTH) | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail     <= tail + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push & ~pop) begin
        count <= count + CW'(1);
      end else if (pop & ~push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule
